// File: rtl/eq_mac_scheduler.sv
// eq_mac_scheduler: sequences one shared MAC across N_BANDS FIR bands of
// N_TAPS taps each, one accepted audio sample per frame.
// Optional feature macro: EQ_MAC_SCHEDULER_BAND_MASK_EN (adds band_mask input
// so that masked-off bands are skipped entirely).
//
// Handshake: sample_valid is a one-cycle strobe with no ready. A strobe seen
// with enable high while IDLE starts a frame; one seen while a frame is in
// progress is dropped and sets the sticky overrun flag; one seen with enable
// low is ignored.
//
// Every output is a register loaded with the value belonging to the state
// being entered, so a tap issued in cycle c is the tap chosen at the edge
// that starts cycle c.
module eq_mac_scheduler #(
    parameter int N_TAPS  = 31,
    parameter int N_BANDS = 3,
    parameter int TAP_W   = $clog2(N_TAPS),
    parameter int BAND_W  = (N_BANDS > 1) ? $clog2(N_BANDS) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     sample_valid,
    input  logic signed [23:0]       sample_in,
`ifdef EQ_MAC_SCHEDULER_BAND_MASK_EN
    input  logic [N_BANDS-1:0]       band_mask,
`endif
    input  logic                     overrun_clr,
    output logic                     dl_wr_en,
    output logic [TAP_W-1:0]         dl_wr_addr,
    output logic signed [23:0]       dl_wr_data,
    output logic [TAP_W-1:0]         tap_addr,
    output logic [BAND_W+TAP_W-1:0]  coef_addr,
    output logic [BAND_W-1:0]        band_id,
    output logic                     mac_en,
    output logic                     mac_clr,
    output logic                     mac_last,
    output logic                     busy,
    output logic                     overrun,
    output logic [1:0]               dbg_state
);

    localparam int CW = BAND_W + TAP_W;
    localparam logic [TAP_W-1:0] K_LAST = TAP_W'(N_TAPS - 1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WRITE = 2'd1, S_RUN = 2'd2} state_t;

    state_t                   state_q, state_d;
    logic [TAP_W-1:0]         k_q, k_d, wp_q, wp_d, wp_inc;
    logic [BAND_W-1:0]        band_q, band_d;
    logic [N_BANDS-1:0]       mask_q, mask_d, mask_src;
    logic                     issue;
    logic [BAND_W:0]          hit;
    logic [TAP_W:0]           diff;

    logic                     dl_wr_en_q, dl_wr_en_d;
    logic [TAP_W-1:0]         dl_wr_addr_q, dl_wr_addr_d;
    logic signed [23:0]       dl_wr_data_q, dl_wr_data_d;
    logic [TAP_W-1:0]         tap_addr_q, tap_addr_d;
    logic [CW-1:0]            coef_addr_q, coef_addr_d;
    logic [BAND_W-1:0]        band_id_q, band_id_d;
    logic                     mac_en_q, mac_en_d, mac_clr_q, mac_clr_d;
    logic                     mac_last_q, mac_last_d, busy_q, busy_d;
    logic                     overrun_q, overrun_d;

`ifdef EQ_MAC_SCHEDULER_BAND_MASK_EN
    assign mask_src = band_mask;
`else
    assign mask_src = {N_BANDS{1'b1}};
`endif

    assign wp_inc = (wp_q == K_LAST) ? '0 : wp_q + 1'b1;

    // Lowest enabled band at or above 'from'; MSB of the result is the found flag.
    function automatic logic [BAND_W:0] find_band(input logic [N_BANDS-1:0] m, input int from);
        logic [BAND_W:0] r;
        r = '0;
        for (int i = N_BANDS - 1; i >= 0; i--) begin
            if (i >= from && m[i]) r = {1'b1, BAND_W'(i)};
        end
        return r;
    endfunction

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        band_d       = band_q;
        wp_d         = wp_q;
        mask_d       = mask_q;
        issue        = 1'b0;
        hit          = '0;
        diff         = '0;
        dl_wr_en_d   = 1'b0;
        dl_wr_addr_d = dl_wr_addr_q;
        dl_wr_data_d = dl_wr_data_q;
        tap_addr_d   = tap_addr_q;
        coef_addr_d  = coef_addr_q;
        band_id_d    = band_id_q;
        mac_en_d     = 1'b0;
        mac_clr_d    = 1'b0;
        mac_last_d   = 1'b0;
        overrun_d    = overrun_q;
        busy_d       = 1'b0;

        if (enable) begin
            case (state_q)
                S_IDLE: begin
                    if (sample_valid) begin
                        state_d      = S_WRITE;
                        dl_wr_en_d   = 1'b1;
                        dl_wr_addr_d = wp_q;
                        dl_wr_data_d = sample_in;
                    end
                end
                S_WRITE: begin
                    mask_d = mask_src;
                    k_d    = '0;
                    hit    = find_band(mask_src, 0);
                    if (hit[BAND_W]) begin
                        band_d  = hit[BAND_W-1:0];
                        state_d = S_RUN;
                        issue   = 1'b1;
                    end else begin
                        band_d  = '0;
                        state_d = S_IDLE;
                        wp_d    = wp_inc;
                    end
                end
                S_RUN: begin
                    if (k_q == K_LAST) begin
                        k_d = '0;
                        hit = find_band(mask_q, int'(band_q) + 1);
                        if (hit[BAND_W]) begin
                            band_d = hit[BAND_W-1:0];
                            issue  = 1'b1;
                        end else begin
                            band_d  = '0;
                            state_d = S_IDLE;
                            wp_d    = wp_inc;
                        end
                    end else begin
                        k_d   = k_q + 1'b1;
                        issue = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Tap k reads the sample written k frames ago; wrap modulo N_TAPS.
        if (issue) begin
            diff = {1'b0, wp_q} + (TAP_W+1)'(N_TAPS) - {1'b0, k_d};
            if (diff >= (TAP_W+1)'(N_TAPS)) diff = diff - (TAP_W+1)'(N_TAPS);
            tap_addr_d  = diff[TAP_W-1:0];
            coef_addr_d = CW'(band_d) * CW'(N_TAPS) + CW'(k_d);
            band_id_d   = band_d;
            mac_en_d    = 1'b1;
            mac_clr_d   = (k_d == '0);
            mac_last_d  = (k_d == K_LAST);
        end

        // A drop in the same cycle as a clear still leaves the flag set.
        if (overrun_clr) overrun_d = 1'b0;
        if (enable && sample_valid && state_q != S_IDLE) overrun_d = 1'b1;

        busy_d = (state_d != S_IDLE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            k_q          <= '0;
            band_q       <= '0;
            wp_q         <= '0;
            mask_q       <= '0;
            dl_wr_en_q   <= 1'b0;
            dl_wr_addr_q <= '0;
            dl_wr_data_q <= '0;
            tap_addr_q   <= '0;
            coef_addr_q  <= '0;
            band_id_q    <= '0;
            mac_en_q     <= 1'b0;
            mac_clr_q    <= 1'b0;
            mac_last_q   <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            band_q       <= band_d;
            wp_q         <= wp_d;
            mask_q       <= mask_d;
            dl_wr_en_q   <= dl_wr_en_d;
            dl_wr_addr_q <= dl_wr_addr_d;
            dl_wr_data_q <= dl_wr_data_d;
            tap_addr_q   <= tap_addr_d;
            coef_addr_q  <= coef_addr_d;
            band_id_q    <= band_id_d;
            mac_en_q     <= mac_en_d;
            mac_clr_q    <= mac_clr_d;
            mac_last_q   <= mac_last_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
        end
    end

    assign dl_wr_en   = dl_wr_en_q;
    assign dl_wr_addr = dl_wr_addr_q;
    assign dl_wr_data = dl_wr_data_q;
    assign tap_addr   = tap_addr_q;
    assign coef_addr  = coef_addr_q;
    assign band_id    = band_id_q;
    assign mac_en     = mac_en_q;
    assign mac_clr    = mac_clr_q;
    assign mac_last   = mac_last_q;
    assign busy       = busy_q;
    assign overrun    = overrun_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_eq_mac_scheduler.sv
// Bench for eq_mac_scheduler: random samples, a frame-level reference model
// that lists the expected tap issues per frame, and directed corner steps.
module tb_eq_mac_scheduler;

    localparam int N_TAPS  = 31;
    localparam int N_BANDS = 3;
    localparam int TAP_W   = 5;
    localparam int BAND_W  = 2;
    localparam int CW      = BAND_W + TAP_W;

    logic clk = 1'b0;
    logic rst, enable, sample_valid, overrun_clr;
    logic [23:0] sample_in;
`ifdef EQ_MAC_SCHEDULER_BAND_MASK_EN
    logic [N_BANDS-1:0] band_mask;
`endif
    logic              dl_wr_en, mac_en, mac_clr, mac_last, busy, overrun;
    logic [TAP_W-1:0]  dl_wr_addr, tap_addr;
    logic [23:0]       dl_wr_data;
    logic [CW-1:0]     coef_addr;
    logic [BAND_W-1:0] band_id;
    logic [1:0]        dbg_state;

    int tests_run = 0;
    int fails = 0;
    int m_wp = 0;
    logic [N_BANDS-1:0] mask_v = '1;
    logic [31:0] exp_q[$];

    eq_mac_scheduler #(.N_TAPS(N_TAPS), .N_BANDS(N_BANDS)) dut (
        .clk(clk), .rst(rst), .enable(enable), .sample_valid(sample_valid),
        .sample_in(sample_in),
`ifdef EQ_MAC_SCHEDULER_BAND_MASK_EN
        .band_mask(band_mask),
`endif
        .overrun_clr(overrun_clr), .dl_wr_en(dl_wr_en), .dl_wr_addr(dl_wr_addr),
        .dl_wr_data(dl_wr_data), .tap_addr(tap_addr), .coef_addr(coef_addr),
        .band_id(band_id), .mac_en(mac_en), .mac_clr(mac_clr), .mac_last(mac_last),
        .busy(busy), .overrun(overrun), .dbg_state(dbg_state)
    );

    // clock / reset block
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: every tap issue of one frame, packed {band, k, tap, coef}.
    task automatic build_frame(input int wp);
        exp_q.delete();
        for (int b = 0; b < N_BANDS; b++) begin
            if (mask_v[b]) begin
                for (int k = 0; k < N_TAPS; k++) begin
                    exp_q.push_back({8'(b), 8'(k), 8'((wp - k + N_TAPS) % N_TAPS), 8'(b * N_TAPS + k)});
                end
            end
        end
    endtask

    // Drive one sample and follow the whole frame. stall_at: issue index after
    // which enable drops for stall_len cycles (-1 none). drop_at: busy-cycle
    // number during which a second sample is offered (-1 none).
    task automatic do_frame(input logic [23:0] s, input int stall_at, input int stall_len,
                            input int drop_at, input logic drop_clr);
        int n_iss, cyc, idx, stall_cnt;
        logic [31:0] e, last_e;
        build_frame(m_wp);
        n_iss = exp_q.size();
        last_e = '0;
        sample_valid = 1'b1;
        sample_in = s;
        step();
        sample_valid = 1'b0;
        sample_in = 24'($urandom);
        chk("wr_en_T1", 32'(dl_wr_en), 32'd1);
        chk("wr_addr", 32'(dl_wr_addr), 32'(m_wp));
        chk("wr_data", 32'(dl_wr_data), 32'(s));
        chk("busy_T1", 32'(busy), 32'd1);
        chk("mac_en_T1", 32'(mac_en), 32'd0);
        cyc = 1;
        idx = 0;
        stall_cnt = 0;
        while (1) begin
            if (cyc == drop_at) begin
                sample_valid = 1'b1;
                sample_in = ~s;
                overrun_clr = drop_clr;
            end
            step();
            if (cyc == drop_at) begin
                sample_valid = 1'b0;
                overrun_clr = 1'b0;
                chk("overrun_set", 32'(overrun), 32'd1);
            end
            if (busy == 1'b0) break;
            cyc++;
            if (cyc > 300) begin
                chk("frame_timeout", 32'd1, 32'd0);
                break;
            end
            chk("wr_en_run", 32'(dl_wr_en), 32'd0);
            if (stall_cnt > 0) begin
                chk("stall_mac_en", 32'(mac_en), 32'd0);
                chk("stall_tap", 32'(tap_addr), 32'(last_e[15:8]));
                chk("stall_coef", 32'(coef_addr), 32'(last_e[7:0]));
                chk("stall_band", 32'(band_id), 32'(last_e[31:24]));
                stall_cnt--;
                if (stall_cnt == 0) enable = 1'b1;
            end else begin
                chk("mac_en", 32'(mac_en), 32'd1);
                if (exp_q.size() == 0) begin
                    chk("extra_issue", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    last_e = e;
                    chk("tap_addr", 32'(tap_addr), 32'(e[15:8]));
                    chk("coef_addr", 32'(coef_addr), 32'(e[7:0]));
                    chk("band_id", 32'(band_id), 32'(e[31:24]));
                    chk("mac_clr", 32'(mac_clr), 32'(e[23:16] == 8'd0));
                    chk("mac_last", 32'(mac_last), 32'(e[23:16] == 8'(N_TAPS - 1)));
                end
                idx++;
                if (idx == stall_at + 1 && stall_len > 0) begin
                    enable = 1'b0;
                    stall_cnt = stall_len;
                end
            end
        end
        chk("issue_count", 32'(idx), 32'(n_iss));
        chk("busy_cycles", 32'(cyc), 32'(1 + n_iss + stall_len));
        chk("mac_en_idle", 32'(mac_en), 32'd0);
        chk("data_kept", 32'(dl_wr_data), 32'(s));
        m_wp = (m_wp + 1) % N_TAPS;
    endtask

    initial begin
        int gap;
        rst = 1'b1;
        enable = 1'b1;
        sample_valid = 1'b0;
        overrun_clr = 1'b0;
        sample_in = '0;
`ifdef EQ_MAC_SCHEDULER_BAND_MASK_EN
        band_mask = '1;
`endif
        step();
        step();
        rst = 1'b0;
        step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mac_en", 32'(mac_en), 32'd0);
        chk("rst_wr_en", 32'(dl_wr_en), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_tap", 32'(tap_addr), 32'd0);
        chk("rst_coef", 32'(coef_addr), 32'd0);

        // Sample offered with enable low is ignored.
        enable = 1'b0;
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        enable = 1'b1;
        step();
        chk("dis_busy", 32'(busy), 32'd0);
        chk("dis_wr_en", 32'(dl_wr_en), 32'd0);
        chk("dis_overrun", 32'(overrun), 32'd0);

        // First frame and a run of frames that wraps the write pointer.
        do_frame(24'h000100, -1, 0, -1, 1'b0);
        for (int f = 0; f < 35; f++) begin
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                step();
                chk("gap_busy", 32'(busy), 32'd0);
            end
            do_frame(24'($urandom), -1, 0, -1, 1'b0);
        end

        // Overrun: drop sets, clear+drop keeps, clear alone clears.
        do_frame(24'($urandom), -1, 0, 50, 1'b0);
        chk("overrun_sticky", 32'(overrun), 32'd1);
        do_frame(24'($urandom), -1, 0, 50, 1'b1);
        chk("overrun_set_wins", 32'(overrun), 32'd1);
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        chk("overrun_cleared", 32'(overrun), 32'd0);

        // Enable low for 10 cycles after band 1 tap 15.
        do_frame(24'($urandom), N_TAPS + 15, 10, -1, 1'b0);

        // Reset at band 0 tap 20.
        sample_valid = 1'b1;
        sample_in = 24'h123456;
        step();
        sample_valid = 1'b0;
        for (int c = 0; c < 21; c++) step();
        chk("pre_rst_coef", 32'(coef_addr), 32'd20);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_mac_en", 32'(mac_en), 32'd0);
        chk("abort_mac_last", 32'(mac_last), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_tap", 32'(tap_addr), 32'd0);
        chk("abort_band", 32'(band_id), 32'd0);
        chk("abort_wr_data", 32'(dl_wr_data), 32'd0);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("abort_quiet", 32'({mac_last, mac_en, busy}), 32'd0);
        end
        m_wp = 0;
        do_frame(24'($urandom), -1, 0, -1, 1'b0);

`ifdef EQ_MAC_SCHEDULER_BAND_MASK_EN
        mask_v = 3'b101;
        band_mask = 3'b101;
        do_frame(24'($urandom), -1, 0, -1, 1'b0);
        mask_v = 3'b000;
        band_mask = 3'b000;
        do_frame(24'($urandom), -1, 0, -1, 1'b0);
        mask_v = '1;
        band_mask = '1;
        do_frame(24'($urandom), -1, 0, -1, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/eq_mac_scheduler.md
# eq_mac_scheduler

- Sequences one shared multiply-accumulate datapath across several FIR equalizer bands, one audio sample at a time.
- Per accepted sample:
  - writes the sample into a circular delay-line memory;
  - walks every band's taps, issuing delay-line read addresses, coefficient addresses and accumulator control strobes;
  - flags samples that arrive while a frame is still in progress.
- Sits between the audio input sample strobe and the shared MAC/coefficient-RAM datapath of the equalizer.

## Interface
Parameters:
- N_TAPS, 31, taps per band (≥2)
- N_BANDS, 3, number of bands sharing the MAC (≥1)
- TAP_W, $clog2(N_TAPS), tap/delay-line address width
- BAND_W, $clog2(N_BANDS) (min 1), band index width

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- enable  in  1  when low, FSM and all counters freeze; mac_en and dl_wr_en forced 0
- sample_valid  in  1  one-cycle strobe, new sample on sample_in
- sample_in  in  24 signed  audio sample
- dl_wr_en  out  1  delay-line write strobe
- dl_wr_addr  out  TAP_W  delay-line write slot
- dl_wr_data  out  24  registered copy of sample_in
- tap_addr  out  TAP_W  delay-line read address
- coef_addr  out  BAND_W+TAP_W  coefficient address = band*N_TAPS + k
- band_id  out  BAND_W  band currently issued
- mac_en  out  1  accumulate product this cycle
- mac_clr  out  1  first tap of a band: load instead of accumulate
- mac_last  out  1  last tap of a band: datapath captures result for band_id
- busy  out  1  frame in progress
- overrun  out  1  sticky, a sample was dropped
- overrun_clr  in  1  clears overrun

## Operation
- FSM states:
  - IDLE: if enable && sample_valid, latch sample, go WRITE.
  - WRITE (1 cycle): dl_wr_en=1 at slot wp; band=0, k=0; go RUN.
  - RUN: one tap per cycle.
    - tap_addr = (wp − k) mod N_TAPS, so tap 0 is the newest sample.
    - mac_clr = (k==0), mac_last = (k==N_TAPS−1).
    - k wraps to 0 and band increments after mac_last.
    - After the last tap of the last band: wp ← (wp+1) mod N_TAPS, go IDLE.
- Address and wrap rules:
  - wp wraps N_TAPS−1 → 0.
  - The subtraction wraps modulo N_TAPS, not modulo 2^TAP_W.
- Overrun: sample_valid with busy=1 (enable high) drops that sample and sets overrun. Set has priority over a simultaneous overrun_clr.
- Enable:
  - enable low in any state holds state, k, band and wp; strobes stay 0.
  - The frame resumes at the same tap when enable returns high.
  - sample_valid while enable is low is ignored and does not set overrun.
- Reset mid-frame: frame aborted, no mac_last issued, state IDLE, wp=0.
- All outputs are registered.

## Timing
- Reset values:
  - all outputs 0;
  - internal wp=0, k=0, band=0, state IDLE.
- sample_valid accepted at cycle T:
  - dl_wr_en at T+1;
  - mac_en high T+2 .. T+1+N_BANDS·N_TAPS, contiguous if enable stays high;
  - busy high T+1 .. T+1+N_BANDS·N_TAPS;
  - IDLE at T+2+N_BANDS·N_TAPS.
- Frame length: 1+N_BANDS·N_TAPS busy cycles (94 for defaults).
- Back-to-back acceptance: a sample_valid on the first cycle busy=0 is accepted.
- The datapath owns MAC pipeline latency. This block issues no drain cycles.

## Configuration
- Macro: EQ_MAC_SCHEDULER_BAND_MASK_EN.
- Defined:
  - adds input port band_mask [N_BANDS−1:0], sampled once per frame in WRITE;
  - bands with mask bit 0 are skipped, with no mac_en/mac_clr/mac_last cycles;
  - frame length becomes 1+popcount(mask)·N_TAPS;
  - mask all-zero: WRITE then straight to IDLE, and wp still advances.
- Undefined: no band_mask port; all bands always run.

## Test plan
- Reset, then single sample 24'h000100 (defaults):
  - dl_wr_en at T+1, addr 0;
  - 93 mac_en cycles;
  - mac_clr at k=0 and mac_last at k=30 for bands 0,1,2;
  - coef_addr runs 0..92;
  - busy drops after 94 cycles.
- 35 consecutive frames:
  - dl_wr_addr runs 0..30 then wraps to 0;
  - in frame with wp=2, tap_addr sequence is 2,1,0,30,29…3.
- sample_valid at T+50 of a running frame:
  - sample dropped, overrun=1, frame unaffected;
  - overrun_clr together with a new drop leaves overrun=1;
  - overrun_clr alone clears it.
- enable low for 10 cycles at k=15 of band 1:
  - outputs hold, mac_en=0;
  - resumes at k=15, total busy = 104 cycles.
- rst at k=20 of band 0: all outputs 0 next cycle, no mac_last, next frame writes slot 0.
- With EQ_MAC_SCHEDULER_BAND_MASK_EN, mask=3'b101: only bands 0 and 2 issued, 62 mac_en cycles, band_id never 1.
